// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// Holds the op encoding (funct3[1:0]) and the FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// q_in carries the unconsumed dividend bits in its MSBs.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] q_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // shift in next dividend bit, trial-subtract, keep or restore
  always_comb begin
    shifted = {rem_in, q_in[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[W]) begin
      rem_out = shifted[W-1:0];
    end else begin
      rem_out = diff[W-1:0];
    end
    q_out = {q_in[W-2:0], ~diff[W]};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer; stalls the core until done.
// Optional: DIV_FAST_SPECIAL_EN sends div-by-zero/overflow IDLE->FIX.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  div_op_t               op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  div_state_t state;
  div_state_t state_nxt;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] a_raw;
  logic                  is_rem;
  logic                  neg_q;
  logic                  neg_r;
  logic                  dz;
  logic                  ovf;

  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_q;
  logic [DATA_WIDTH-1:0] fix_val;

  logic sgn_in;
  logic a_neg;
  logic b_neg;
  logic dz_in;
  logic ovf_in;
  logic fast;

  assign sgn_in = ~op[0];
  assign a_neg  = sgn_in & dividend[DATA_WIDTH-1];
  assign b_neg  = sgn_in & divisor[DATA_WIDTH-1];
  assign dz_in  = (divisor == '0);
  assign ovf_in = sgn_in & (dividend == MIN_NEG) & (&divisor);

`ifdef DIV_FAST_SPECIAL_EN
  assign fast = dz_in | ovf_in;
`else
  assign fast = 1'b0;
`endif

  div_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .rem_in  (rem),
    .q_in    (quo),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = fast ? FIX : CALC;
      CALC: if (count == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs; stall is masked while reset is held
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    stall = ~reset & (((state == IDLE) & start) |
                      (state == CALC) | (state == FIX));
  end

  // final value: special cases first, then sign fix-up
  always_comb begin
    if (dz) begin
      fix_val = is_rem ? a_raw : '1;
    end else if (ovf) begin
      fix_val = is_rem ? '0 : MIN_NEG;
    end else if (is_rem) begin
      fix_val = neg_r ? -rem : rem;
    end else begin
      fix_val = neg_q ? -quo : quo;
    end
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          count  <= '0;
          rem    <= '0;
          quo    <= a_neg ? -dividend : dividend;
          dvs    <= b_neg ? -divisor : divisor;
          a_raw  <= dividend;
          is_rem <= op[1];
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          dz     <= dz_in;
          ovf    <= ovf_in;
        end
        CALC: begin
          rem   <= step_rem;
          quo   <= step_q;
          count <= count + 1'b1;
        end
        FIX:  result <= fix_val;
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
